// File: rtl/delay_commutator_pkg.sv
// -----------------------------------------------------------------------------
// delay_commutator_pkg
// Shared definitions for the delay commutator and its delay lines:
//   NBITS_DEF   - default width of one real or imaginary component
//   CPLX_W_DEF  - default complex word width (real in upper half)
//   cplx_width  - complex word width for a given component width
//   cnt_width   - sample counter width for a given commutator span
// -----------------------------------------------------------------------------
package delay_commutator_pkg;

    localparam int NBITS_DEF  = 16;
    localparam int CPLX_W_DEF = 2 * NBITS_DEF;

    function automatic int cplx_width(input int nbits);
        return 2 * nbits;
    endfunction

    // Counter spans 2*DELAY samples; its MSB is the switch select.
    function automatic int cnt_width(input int delay);
        return $clog2(delay) + 1;
    endfunction

endpackage

// File: rtl/sample_delay.sv
// -----------------------------------------------------------------------------
// sample_delay
// Enable-gated shift register: q_o equals the d_i presented DEPTH enables ago.
// Idle cycles (en_i=0) do not advance the line.
// Ports:
//   clk_i   - rising-edge clock
//   rst_ni  - asynchronous active-low clear (all taps to 0)
//   en_i    - advance the line by one sample
//   d_i     - sample entering the line
//   q_o     - sample leaving the line
// -----------------------------------------------------------------------------
module sample_delay #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] tap_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                tap_q[i] <= '0;
            end
        end else if (en_i) begin
            tap_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                tap_q[i] <= tap_q[i-1];
            end
        end
    end

    assign q_o = tap_q[DEPTH-1];

endmodule

// File: rtl/delay_commutator.sv
// -----------------------------------------------------------------------------
// delay_commutator
// Delay-switch-delay reorder stage for one lane pair of the parallel-4 FFT.
// Lane A is delayed by DELAY samples, then the switch either passes the lanes
// straight (sel=0) or crosses them (sel=1); the lower result is delayed by
// another DELAY samples. Bubbles (in_valid=0) freeze all state.
//
// Optional build macro: DCOM_FRAME_SYNC_EN adds out_sync, which flags the
// first output of each 2*DELAY-sample block.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-low reset
//   in_valid  - qualifies in_a/in_b
//   in_a      - upper-lane complex sample {re, im}
//   in_b      - lower-lane complex sample {re, im}
//   out_valid - qualifies out_a/out_b
//   out_a     - upper-lane reordered sample
//   out_b     - lower-lane reordered sample
//   out_sync  - (DCOM_FRAME_SYNC_EN only) block-start marker
// -----------------------------------------------------------------------------
module delay_commutator
    import delay_commutator_pkg::*;
#(
    parameter int NBITS = NBITS_DEF,
    parameter int DELAY = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [2*NBITS-1:0]   in_a,
    input  logic [2*NBITS-1:0]   in_b,
    output logic                 out_valid,
    output logic [2*NBITS-1:0]   out_a,
    output logic [2*NBITS-1:0]   out_b
`ifdef DCOM_FRAME_SYNC_EN
    ,
    output logic                 out_sync
`endif
);

    localparam int CW   = cplx_width(NBITS);
    localparam int CNTW = cnt_width(DELAY);

    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            primed_q, primed_d;
    logic            out_valid_q, out_valid_d;
    logic [CW-1:0]   out_a_q, out_a_d;
    logic [CW-1:0]   out_b_q, out_b_d;

    logic            sel;
    logic [CW-1:0]   line_a_out;
    logic [CW-1:0]   line_b_out;
    logic [CW-1:0]   sw_top;
    logic [CW-1:0]   sw_bot;

    sample_delay #(
        .WIDTH (CW),
        .DEPTH (DELAY)
    ) u_line_a (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (in_valid),
        .d_i    (in_a),
        .q_o    (line_a_out)
    );

    sample_delay #(
        .WIDTH (CW),
        .DEPTH (DELAY)
    ) u_line_b (
        .clk_i  (clk),
        .rst_ni (rst),
        .en_i   (in_valid),
        .d_i    (sw_bot),
        .q_o    (line_b_out)
    );

    // 2^CNTW == 2*DELAY because DELAY is a power of two, so the natural
    // binary wrap gives the modulo-2*DELAY count.
    assign sel    = cnt_q[CNTW-1];
    assign sw_top = sel ? in_b       : line_a_out;
    assign sw_bot = sel ? line_a_out : in_b;

    always_comb begin
        cnt_d       = cnt_q;
        primed_d    = primed_q;
        out_valid_d = 1'b0;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        if (in_valid) begin
            cnt_d       = cnt_q + CNTW'(1);
            // The last sample of the first block fills line B; the next
            // accepted sample is the first one with real data on both lanes.
            if (cnt_q == {CNTW{1'b1}}) begin
                primed_d = 1'b1;
            end
            out_valid_d = primed_q;
            out_a_d     = sw_top;
            out_b_d     = line_b_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;

`ifdef DCOM_FRAME_SYNC_EN
    logic out_sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_sync_q <= 1'b0;
        end else begin
            out_sync_q <= in_valid && primed_q && (cnt_q == '0);
        end
    end

    assign out_sync = out_sync_q;
`endif

endmodule

// File: tb/tb_delay_commutator.sv
// -----------------------------------------------------------------------------
// tb_delay_commutator
// Two instances: DELAY=4 and DELAY=1, NBITS=16. Fixed tables cover the
// continuous streams; an index-based reference model feeds a scoreboard for
// the bubble, reset, integrity and random streams on the DELAY=4 instance.
// -----------------------------------------------------------------------------
module tb_delay_commutator;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_a, in_b;
    logic         out_valid;
    logic [W-1:0] out_a, out_b;

    logic         v1;
    logic [W-1:0] a1, b1;
    logic         ov1;
    logic [W-1:0] oa1, ob1;

`ifdef DCOM_FRAME_SYNC_EN
    logic         out_sync;
    logic         os1;
`endif

    always #5 clk = ~clk;

    delay_commutator #(.NBITS(16), .DELAY(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_a     (out_a),
        .out_b     (out_b)
`ifdef DCOM_FRAME_SYNC_EN
        ,
        .out_sync  (out_sync)
`endif
    );

    delay_commutator #(.NBITS(16), .DELAY(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .in_a      (a1),
        .in_b      (b1),
        .out_valid (ov1),
        .out_a     (oa1),
        .out_b     (ob1)
`ifdef DCOM_FRAME_SYNC_EN
        ,
        .out_sync  (os1)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic         v;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ev;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic         es;
    } vec_t;

    vec_t tbl4 [16];
    vec_t tbl1 [6];

    // ---------------- reference model (DELAY=4) ----------------
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
    } exp_t;

    exp_t         sbq[$];
    int           mn;
    logic [W-1:0] hist_a [1024];
    logic [W-1:0] hist_bot [1024];
    logic         m_primed;
    logic [W-1:0] m_oa, m_ob;

    task automatic model_reset();
        mn       = 0;
        m_primed = 1'b0;
        m_oa     = '0;
        m_ob     = '0;
        sbq.delete();
    endtask

    task automatic drive4(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        logic         ev;
        logic [W-1:0] t, top, bot, d;
        exp_t         e;
        ev = v && m_primed;
        in_valid = v;
        in_a     = a;
        in_b     = b;
        if (v) begin
            if (mn >= 1000) begin
                $display("FAIL model_depth: got %0d expected below 1000", mn);
                n_err++;
                $fatal(1, "model history exhausted");
            end
            t   = (mn >= 4) ? hist_a[mn-4] : '0;
            top = ((mn % 8) >= 4) ? b : t;
            bot = ((mn % 8) >= 4) ? t : b;
            d   = (mn >= 4) ? hist_bot[mn-4] : '0;
            hist_a[mn]   = a;
            hist_bot[mn] = bot;
            if (m_primed) sbq.push_back('{top, d, (mn % 8) == 0});
            m_oa = top;
            m_ob = d;
            if ((mn % 8) == 7) m_primed = 1'b1;
            mn++;
        end
        @(posedge clk);
        #1;
        chk("sb_valid", {31'b0, out_valid}, {31'b0, ev});
        if (ev) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = sbq.pop_front();
                chk("sb_out_a", out_a, e.a);
                chk("sb_out_b", out_b, e.b);
`ifdef DCOM_FRAME_SYNC_EN
                chk("sb_sync", {31'b0, out_sync}, {31'b0, e.s});
`endif
            end
        end else begin
            chk("hold_out_a", out_a, m_oa);
            chk("hold_out_b", out_b, m_ob);
`ifdef DCOM_FRAME_SYNC_EN
            chk("hold_sync", {31'b0, out_sync}, 32'd0);
`endif
        end
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        v1       = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        model_reset();
    endtask

    task automatic chk_zero4(input string tag);
        chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_out_a"}, out_a, 32'd0);
        chk({tag, "_out_b"}, out_b, 32'd0);
`ifdef DCOM_FRAME_SYNC_EN
        chk({tag, "_sync"}, {31'b0, out_sync}, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Scenario 1, DELAY=4: in_a=k, in_b=100+k.
        for (int k = 0; k < 16; k++) begin
            tbl4[k].v  = 1'b1;
            tbl4[k].a  = W'(k);
            tbl4[k].b  = W'(100 + k);
            tbl4[k].ev = (k >= 8);
            tbl4[k].es = (k == 8);
            if (k < 4) begin
                tbl4[k].ea = '0;
                tbl4[k].eb = '0;
            end else if (k < 8 || k >= 12) begin
                tbl4[k].ea = W'(100 + k);
                tbl4[k].eb = W'(96 + k);
            end else begin
                tbl4[k].ea = W'(k - 4);
                tbl4[k].eb = W'(k - 8);
            end
        end
        // DELAY=1: top(n)=in_a(n-1) on even n, in_b(n) on odd n;
        // out_b(n)=bot(n-1).
        tbl1[0] = '{1'b1, 32'd0, 32'd100, 1'b0, 32'd0,   32'd0,   1'b0};
        tbl1[1] = '{1'b1, 32'd1, 32'd101, 1'b0, 32'd101, 32'd100, 1'b0};
        tbl1[2] = '{1'b1, 32'd2, 32'd102, 1'b1, 32'd1,   32'd0,   1'b1};
        tbl1[3] = '{1'b1, 32'd3, 32'd103, 1'b1, 32'd103, 32'd102, 1'b0};
        tbl1[4] = '{1'b1, 32'd4, 32'd104, 1'b1, 32'd3,   32'd2,   1'b1};
        tbl1[5] = '{1'b1, 32'd5, 32'd105, 1'b1, 32'd105, 32'd104, 1'b0};

        rst      = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        v1       = 1'b0;
        a1       = '0;
        b1       = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_zero4("rst_init");
        chk("rst_init_d1_valid", {31'b0, ov1}, 32'd0);
        chk("rst_init_d1_a", oa1, 32'd0);
        #3 rst = 1'b1;

        // Scenario 1: continuous stream, table driven.
        for (int i = 0; i < 16; i++) begin
            in_valid = tbl4[i].v;
            in_a     = tbl4[i].a;
            in_b     = tbl4[i].b;
            @(posedge clk);
            #1;
            chk("t4_valid", {31'b0, out_valid}, {31'b0, tbl4[i].ev});
            chk("t4_out_a", out_a, tbl4[i].ea);
            chk("t4_out_b", out_b, tbl4[i].eb);
`ifdef DCOM_FRAME_SYNC_EN
            chk("t4_sync", {31'b0, out_sync}, {31'b0, tbl4[i].es});
`endif
        end
        in_valid = 1'b0;

        // DELAY=1 stream, table driven.
        for (int i = 0; i < 6; i++) begin
            v1 = tbl1[i].v;
            a1 = tbl1[i].a;
            b1 = tbl1[i].b;
            @(posedge clk);
            #1;
            chk("t1_valid", {31'b0, ov1}, {31'b0, tbl1[i].ev});
            chk("t1_out_a", oa1, tbl1[i].ea);
            chk("t1_out_b", ob1, tbl1[i].eb);
`ifdef DCOM_FRAME_SYNC_EN
            chk("t1_sync", {31'b0, os1}, {31'b0, tbl1[i].es});
`endif
        end
        v1 = 1'b0;
        @(posedge clk);
        #1;
        chk("t1_bubble_valid", {31'b0, ov1}, 32'd0);
        chk("t1_bubble_hold", oa1, 32'd105);

        // Scenario 2: bubble after every accepted sample.
        pulse_reset();
        for (int k = 0; k < 16; k++) begin
            drive4(1'b1, W'(k), W'(100 + k));
            drive4(1'b0, $urandom(), $urandom());
        end

        // Scenario 3: asynchronous reset mid-block, then replay.
        pulse_reset();
        for (int k = 0; k <= 10; k++) begin
            drive4(1'b1, W'(k), W'(100 + k));
        end
        #2 rst = 1'b0;
        #1;
        chk_zero4("rst_async");
        model_reset();
        in_valid = 1'b1;
        in_a     = 32'hDEAD_BEEF;
        in_b     = 32'hCAFE_F00D;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_zero4("rst_held");
        end
        #3 rst = 1'b1;
        in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            drive4(1'b1, W'(k), W'(100 + k));
        end

        // Component integrity: n=20 sits in a crossed block, so its in_a
        // returns on out_a at n=24.
        for (int n = 16; n < 24; n++) begin
            if (n == 20) drive4(1'b1, 32'h8000_7FFF, $urandom());
            else         drive4(1'b1, $urandom(), $urandom());
        end
        drive4(1'b1, $urandom(), $urandom());
        chk("integrity_out_a", out_a, 32'h8000_7FFF);

        // Random data with random bubbles.
        for (int i = 0; i < 80; i++) begin
            drive4(1'($urandom_range(0, 3) != 0), $urandom(), $urandom());
        end
        chk("sb_drained", W'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
